// File: rtl/funct_generator_pkg.sv
// rtl/funct_generator_pkg.sv - shared sizing constants for the function generator sample FIFO
package funct_generator_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEPTH              = 1 << DEFAULT_ADDR_WIDTH;

endpackage

// File: rtl/funct_generator_fifo_mem.sv
// rtl/funct_generator_fifo_mem.sv - simple dual-port sample RAM, synchronous write, registered read
module funct_generator_fifo_mem
  import funct_generator_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         wr_en_i,
  input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
  input  logic signed [DATA_WIDTH-1:0] wr_data_i,
  input  logic                         rd_en_i,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_i,
  output logic signed [DATA_WIDTH-1:0] rd_data_o
);

  logic signed [DATA_WIDTH-1:0] mem_q [1 << ADDR_WIDTH];
  logic signed [DATA_WIDTH-1:0] rd_data_q;

  // No reset: contents are only ever observed after a write has filled them.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/funct_generator_fifo.sv
// rtl/funct_generator_fifo.sv - sample FIFO between the function generator and its consumer
module funct_generator_fifo
  import funct_generator_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_TH   = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         rd_en_i,
  input  logic                         clr_err_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         rd_valid_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         afull_o,
  output logic [ADDR_WIDTH:0]          count_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic                         rd_valid_q;
  logic                         overflow_q, overflow_d;
  logic                         underflow_q, underflow_d;
  logic signed [DATA_WIDTH-1:0] hold_q;
  logic signed [DATA_WIDTH-1:0] mem_rdata;
  logic                         wr_accept, rd_accept;

  // Flags depend only on registered pointers, never on the request inputs.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign afull_o = (count_o >= PW'(AFULL_TH));

  assign wr_accept = wr_en_i && !full_o && !rst;
  assign rd_accept = rd_en_i && !empty_o && !rst;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (clr_err_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    // A new error event in the same cycle as a clear keeps the flag set.
    if (wr_en_i && full_o) begin
      overflow_d = 1'b1;
    end
    if (rd_en_i && empty_o) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_valid_q  <= rd_accept;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (rd_valid_q) begin
        hold_q <= mem_rdata;
      end
    end
  end

  // The RAM read register cannot be reset, so data_o shows it only in the
  // valid cycle and otherwise the last delivered word (zero after reset).
  assign data_o      = rd_valid_q ? mem_rdata : hold_q;
  assign rd_valid_o  = rd_valid_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  funct_generator_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i (data_i),
    .rd_en_i   (rd_accept),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (mem_rdata)
  );

endmodule

// File: tb/tb_funct_generator_fifo.sv
// tb/tb_funct_generator_fifo.sv - directed self-checking bench for funct_generator_fifo
module tb_funct_generator_fifo;

  logic               clk = 1'b0;
  logic               rst;
  logic               wr_en_i;
  logic signed [31:0] data_i;
  logic               rd_en_i;
  logic               clr_err_i;
  logic signed [31:0] data_o;
  logic               rd_valid_o;
  logic               full_o, empty_o, afull_o;
  logic [4:0]         count_o;
  logic               overflow_o, underflow_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  funct_generator_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en_i),
    .data_i      (data_i),
    .rd_en_i     (rd_en_i),
    .clr_err_i   (clr_err_i),
    .data_o      (data_o),
    .rd_valid_o  (rd_valid_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .afull_o     (afull_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en_i = 1'b0; rd_en_i = 1'b0; clr_err_i = 1'b0; data_i = '0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_empty", 32'(empty_o), 1);
    check_eq("rst_full", 32'(full_o), 0);
    check_eq("rst_afull", 32'(afull_o), 0);
    check_eq("rst_count", 32'(count_o), 0);
    check_eq("rst_data", data_o, 0);
    check_eq("rst_valid", 32'(rd_valid_o), 0);
    check_eq("rst_ovf", 32'(overflow_o), 0);
    check_eq("rst_udf", 32'(underflow_o), 0);

    // Fill with 1..16
    for (int i = 1; i <= 16; i++) begin
      wr_en_i = 1'b1; data_i = i;
      tick();
      check_eq($sformatf("fill_count_%0d", i), 32'(count_o), i);
      check_eq($sformatf("fill_afull_%0d", i), 32'(afull_o), (i >= 12) ? 1 : 0);
      check_eq($sformatf("fill_full_%0d", i), 32'(full_o), (i == 16) ? 1 : 0);
    end

    data_i = 32'hDEADBEEF;
    tick();
    wr_en_i = 1'b0;
    check_eq("ovf_set", 32'(overflow_o), 1);
    check_eq("ovf_count", 32'(count_o), 16);

    // Drain; the first read coincides with a dropped write while full
    for (int i = 1; i <= 16; i++) begin
      rd_en_i = 1'b1;
      wr_en_i = (i == 1);
      data_i  = 32'hDEADBEEF;
      tick();
      check_eq($sformatf("drain_valid_%0d", i), 32'(rd_valid_o), 1);
      check_eq($sformatf("drain_data_%0d", i), data_o, i);
      check_eq($sformatf("drain_count_%0d", i), 32'(count_o), 16 - i);
    end
    rd_en_i = 1'b0; wr_en_i = 1'b0;
    tick();
    check_eq("drain_valid_low", 32'(rd_valid_o), 0);
    check_eq("drain_hold", data_o, 16);
    check_eq("drain_empty", 32'(empty_o), 1);

    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    check_eq("ovf_clr", 32'(overflow_o), 0);

    // Underflow from empty
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    check_eq("udf_set", 32'(underflow_o), 1);
    check_eq("udf_valid", 32'(rd_valid_o), 0);
    check_eq("udf_hold", data_o, 16);
    rd_en_i = 1'b1; clr_err_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    check_eq("udf_set_wins", 32'(underflow_o), 1);
    tick();
    clr_err_i = 1'b0;
    check_eq("udf_clr", 32'(underflow_o), 0);

    // Occupancy 5, then 40 cycles of simultaneous write and read across wrap
    for (int i = 0; i < 5; i++) begin
      wr_en_i = 1'b1; data_i = 100 + i;
      tick();
    end
    check_eq("occ5_count", 32'(count_o), 5);
    rd_en_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      data_i = 105 + k;
      tick();
      check_eq($sformatf("stream_count_%0d", k), 32'(count_o), 5);
      check_eq($sformatf("stream_valid_%0d", k), 32'(rd_valid_o), 1);
      check_eq($sformatf("stream_data_%0d", k), data_o, 100 + k);
    end
    rd_en_i = 1'b0;

    // Bring to 9 words, then reset with a write pending
    for (int i = 0; i < 4; i++) begin
      data_i = 200 + i;
      tick();
    end
    wr_en_i = 1'b0;
    check_eq("pre_rst_count", 32'(count_o), 9);
    rst = 1'b1; wr_en_i = 1'b1; rd_en_i = 1'b1; data_i = 32'hAAAA5555;
    tick();
    rst = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0;
    check_eq("mid_rst_empty", 32'(empty_o), 1);
    check_eq("mid_rst_count", 32'(count_o), 0);
    check_eq("mid_rst_data", data_o, 0);
    check_eq("mid_rst_valid", 32'(rd_valid_o), 0);

    // Simultaneous write/read while empty
    wr_en_i = 1'b1; rd_en_i = 1'b1; data_i = 32'h7FFFFFFF;
    tick();
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    check_eq("emp_wr_rd_count", 32'(count_o), 1);
    check_eq("emp_wr_rd_udf", 32'(underflow_o), 1);
    check_eq("emp_wr_rd_valid", 32'(rd_valid_o), 0);
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    check_eq("emp_wr_rd_data", data_o, 32'h7FFFFFFF);
    check_eq("emp_wr_rd_rvalid", 32'(rd_valid_o), 1);
    check_eq("emp_wr_rd_empty", 32'(empty_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/funct_generator_fifo.md
FUNCT_GENERATOR_FIFO -- requirements
Module: funct_generator_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the sample width; it matches the generator output word.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the depth to 2**ADDR_WIDTH words (16).
REQ-003 Parameter AFULL_TH, default 12, SHALL set the almost-full threshold in words, legal range 1..2**ADDR_WIDTH.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port wr_en_i, input, 1: write request, driven by the generator's write-enable output.
REQ-007 Port data_i, input, DATA_WIDTH, signed: write data, driven by the generator's data output.
REQ-008 Port rd_en_i, input, 1: read request from the consumer.
REQ-009 Port clr_err_i, input, 1: clears the sticky error flags.
REQ-010 Port data_o, output, DATA_WIDTH, signed: read data.
REQ-011 Port rd_valid_o, output, 1: data_o holds a newly read word this cycle.
REQ-012 Port full_o, empty_o, afull_o, outputs, 1 each: status flags.
REQ-013 Port count_o, output, ADDR_WIDTH+1: current occupancy.
REQ-014 Ports overflow_o and underflow_o, outputs, 1 each: sticky error flags.

Function
REQ-015 Write accept SHALL be wr_en_i && !full_o; an accepted write stores data_i at wr_ptr, then wr_ptr increments.
REQ-016 Read accept SHALL be rd_en_i && !empty_o; an accepted read loads mem[rd_ptr] into data_o, then rd_ptr increments.
REQ-017 Read latency SHALL be 1 cycle: rd_valid_o is high in the cycle after an accepted read and low otherwise.
REQ-018 data_o SHALL hold its last value when no read is accepted.
REQ-019 Pointers SHALL be ADDR_WIDTH+1 bits; the MSB is a wrap bit, and increments wrap modulo 2**(ADDR_WIDTH+1).
REQ-020 empty_o SHALL be high when the pointers are equal.
REQ-021 full_o SHALL be high when the pointer LSBs are equal and the MSBs differ.
REQ-022 count_o SHALL equal wr_ptr - rd_ptr modulo 2**(ADDR_WIDTH+1), with a range of 0..2**ADDR_WIDTH.
REQ-023 afull_o SHALL be high when count_o >= AFULL_TH.
REQ-024 All flags SHALL be registered or derived from registered pointers only; there SHALL be no combinational path from wr_en_i or rd_en_i.
REQ-025 Simultaneous write and read when neither full nor empty: both SHALL be accepted and count_o is unchanged.
REQ-026 Simultaneous write and read when full: only the read SHALL be accepted; the write is dropped and overflow_o is set.
REQ-027 Simultaneous write and read when empty: only the write SHALL be accepted; the read is ignored and underflow_o is set.
REQ-028 wr_en_i while full SHALL drop the data, leave the memory unchanged, and set overflow_o.
REQ-029 rd_en_i while empty SHALL leave data_o unchanged, keep rd_valid_o low, and set underflow_o.
REQ-030 overflow_o and underflow_o SHALL stay high until clr_err_i.
REQ-031 If clr_err_i coincides with a new error event, the flag SHALL remain set (set wins).

Reset
REQ-032 When rst is sampled high, the block SHALL set: pointers 0, data_o 0, rd_valid_o 0, overflow_o 0, underflow_o 0; hence empty_o=1, full_o=0, afull_o=0, count_o=0.
REQ-033 rst SHALL override all simultaneous wr_en_i, rd_en_i and clr_err_i in the same cycle.
REQ-034 Reset mid-operation SHALL discard all stored words; memory contents need not be cleared.

Structure
REQ-035 Package funct_generator_pkg SHALL hold the default DATA_WIDTH, the default ADDR_WIDTH, and a derived DEPTH constant.
REQ-036 Storage SHALL be a sub-module funct_generator_fifo_mem: a simple dual-port RAM with a synchronous write port and a synchronous registered read port, with no reset.
REQ-037 Pointer, flag and error logic SHALL reside in funct_generator_fifo.

Verification
REQ-038 Reset, then 16 writes of 0x00000001..0x00000010 with no reads: full_o=1 after the 16th write; afull_o rises when count_o reaches 12; count_o=16.
REQ-039 From full, a 17th write of 0xDEADBEEF: overflow_o=1; count_o stays 16; subsequent reads return 0x01..0x10 in order, each with rd_valid_o 1 cycle after rd_en_i.
REQ-040 From empty, rd_en_i for 1 cycle: underflow_o=1, rd_valid_o=0, data_o unchanged; a clr_err_i pulse returns underflow_o to 0.
REQ-041 With occupancy 5, hold wr_en_i and rd_en_i for 40 cycles with incrementing data: count_o stays 5; read order is preserved across pointer wrap.
REQ-042 Assert rst for 1 cycle with 9 words stored and wr_en_i high: next cycle empty_o=1, count_o=0, data_o=0; the word presented during rst is not stored.
REQ-043 When empty, assert wr_en_i and rd_en_i together with data 0x7FFFFFFF: count_o=1, underflow_o=1; the next read returns 0x7FFFFFFF.
